// File: rtl/ym3438_timers.sv
// YM3438 Timer A / Timer B block.
// Counts per-sample ticks from the fsm, raises the status flags and IRQ,
// and produces the Timer A overflow strobe that drives CSM key-on.
// All state advances only on MCLK edges where the c1 phase enable is high;
// IC is a synchronous reset that ignores c1.
module ym3438_timers #(
   parameter int A_W   = 10,
   parameter int B_W   = 8,
   parameter int B_PRE = 16
) (
   input  logic           MCLK,
   input  logic           IC,
   input  logic           c1,
   input  logic           sample_tick,
   input  logic [A_W-1:0] timer_a_val,
   input  logic [B_W-1:0] timer_b_val,
   input  logic           load_a,
   input  logic           load_b,
   input  logic           en_a,
   input  logic           en_b,
   input  logic           clr_a,
   input  logic           clr_b,
   output logic           timer_a,
   output logic           timer_b,
   output logic           irq,
   output logic           ovf_a,
   output logic [A_W-1:0] cnt_a,
   output logic [B_W-1:0] cnt_b
);

   // A single-stage prescaler still needs one register bit.
   localparam int PRE_W = (B_PRE > 1) ? $clog2(B_PRE) : 1;

   localparam logic [A_W-1:0]   A_ONES  = {A_W{1'b1}};
   localparam logic [A_W-1:0]   A_ONE   = A_W'(1);
   localparam logic [B_W-1:0]   B_ONES  = {B_W{1'b1}};
   localparam logic [B_W-1:0]   B_ONE   = B_W'(1);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(B_PRE - 1);
   localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

   logic [A_W-1:0]   cnt_a_q, cnt_a_d;
   logic [B_W-1:0]   cnt_b_q, cnt_b_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             flag_a_q, flag_a_d;
   logic             flag_b_q, flag_b_d;
   logic             ovf_a_q, ovf_a_d;
   logic             ovf_a_tick;
   logic             ovf_b_tick;

   // Timer A: preload while stopped, count ticks while running, reload on overflow.
   always_comb begin
      cnt_a_d    = cnt_a_q;
      ovf_a_tick = 1'b0;
      if (c1) begin
         if (!load_a) begin
            cnt_a_d = timer_a_val;
         end else if (sample_tick) begin
            if (cnt_a_q == A_ONES) begin
               ovf_a_tick = 1'b1;
               cnt_a_d    = timer_a_val;
            end else begin
               cnt_a_d = cnt_a_q + A_ONE;
            end
         end
      end
   end

   // Timer B: the prescaler divides ticks by B_PRE; the counter advances on its wrap.
   always_comb begin
      cnt_b_d    = cnt_b_q;
      pre_d      = pre_q;
      ovf_b_tick = 1'b0;
      if (c1) begin
         if (!load_b) begin
            cnt_b_d = timer_b_val;
            pre_d   = '0;
         end else if (sample_tick) begin
            if (pre_q == PRE_MAX) begin
               pre_d = '0;
               if (cnt_b_q == B_ONES) begin
                  ovf_b_tick = 1'b1;
                  cnt_b_d    = timer_b_val;
               end else begin
                  cnt_b_d = cnt_b_q + B_ONE;
               end
            end else begin
               pre_d = pre_q + PRE_ONE;
            end
         end
      end
   end

   // Flags: an enabled overflow sets (and beats a simultaneous clear); clr_x clears on upd.
   always_comb begin
      flag_a_d = flag_a_q;
      flag_b_d = flag_b_q;
      ovf_a_d  = c1 ? ovf_a_tick : ovf_a_q;
      if (ovf_a_tick && en_a) begin
         flag_a_d = 1'b1;
      end else if (c1 && clr_a) begin
         flag_a_d = 1'b0;
      end
      if (ovf_b_tick && en_b) begin
         flag_b_d = 1'b1;
      end else if (c1 && clr_b) begin
         flag_b_d = 1'b0;
      end
   end

   // State registers; IC clears everything regardless of c1.
   always_ff @(posedge MCLK) begin
      if (IC) begin
         cnt_a_q  <= '0;
         cnt_b_q  <= '0;
         pre_q    <= '0;
         flag_a_q <= 1'b0;
         flag_b_q <= 1'b0;
         ovf_a_q  <= 1'b0;
      end else begin
         cnt_a_q  <= cnt_a_d;
         cnt_b_q  <= cnt_b_d;
         pre_q    <= pre_d;
         flag_a_q <= flag_a_d;
         flag_b_q <= flag_b_d;
         ovf_a_q  <= ovf_a_d;
      end
   end

   assign timer_a = flag_a_q;
   assign timer_b = flag_b_q;
   assign irq     = flag_a_q | flag_b_q;
   assign ovf_a   = ovf_a_q;
   assign cnt_a   = cnt_a_q;
   assign cnt_b   = cnt_b_q;

endmodule

// File: tb/tb_ym3438_timers.sv
// Directed bench for ym3438_timers: expectations are queued as each step is
// driven and drained/compared right after the MCLK edge that processes it.
module tb_ym3438_timers;

   localparam int A_W   = 10;
   localparam int B_W   = 8;
   localparam int B_PRE = 16;

   logic           MCLK = 1'b0;
   logic           IC, c1, sample_tick;
   logic [A_W-1:0] timer_a_val;
   logic [B_W-1:0] timer_b_val;
   logic           load_a, load_b, en_a, en_b, clr_a, clr_b;
   logic           timer_a, timer_b, irq, ovf_a;
   logic [A_W-1:0] cnt_a;
   logic [B_W-1:0] cnt_b;

   ym3438_timers #(.A_W(A_W), .B_W(B_W), .B_PRE(B_PRE)) dut (
      .MCLK(MCLK), .IC(IC), .c1(c1), .sample_tick(sample_tick),
      .timer_a_val(timer_a_val), .timer_b_val(timer_b_val),
      .load_a(load_a), .load_b(load_b), .en_a(en_a), .en_b(en_b),
      .clr_a(clr_a), .clr_b(clr_b),
      .timer_a(timer_a), .timer_b(timer_b), .irq(irq), .ovf_a(ovf_a),
      .cnt_a(cnt_a), .cnt_b(cnt_b)
   );

   always #5 MCLK = ~MCLK;

   typedef enum int {S_TA, S_TB, S_IRQ, S_OVF, S_CA, S_CB} sel_t;
   typedef struct {
      string       tag;
      sel_t        sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   function automatic logic [31:0] obs_of(input sel_t s);
      case (s)
         S_TA:    return {31'b0, timer_a};
         S_TB:    return {31'b0, timer_b};
         S_IRQ:   return {31'b0, irq};
         S_OVF:   return {31'b0, ovf_a};
         S_CA:    return {{(32-A_W){1'b0}}, cnt_a};
         default: return {{(32-B_W){1'b0}}, cnt_b};
      endcase
   endfunction

   task automatic push(input string tag, input sel_t s, input int v);
      exp_t e;
      e.tag = tag;
      e.sel = s;
      e.val = 32'(v);
      sb.push_back(e);
   endtask

   // Timer A view: counter, flag, strobe, and irq (Timer B flag is 0 there).
   task automatic ea(input string tag, input int ca, input int ta, input int ov);
      push({tag, ".cnt_a"}, S_CA, ca);
      push({tag, ".timer_a"}, S_TA, ta);
      push({tag, ".ovf_a"}, S_OVF, ov);
      push({tag, ".irq"}, S_IRQ, ta);
   endtask

   task automatic all_zero(input string tag);
      push({tag, ".cnt_a"}, S_CA, 0);
      push({tag, ".cnt_b"}, S_CB, 0);
      push({tag, ".timer_a"}, S_TA, 0);
      push({tag, ".timer_b"}, S_TB, 0);
      push({tag, ".irq"}, S_IRQ, 0);
      push({tag, ".ovf_a"}, S_OVF, 0);
   endtask

   task automatic clk_check();
      exp_t        e;
      logic [31:0] o;
      @(posedge MCLK);
      #1;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         o = obs_of(e.sel);
         tests++;
         assert (o === e.val) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", e.tag, o, e.val);
         end
      end
   endtask

   task automatic drv(input logic c, input logic t);
      c1          = c;
      sample_tick = t;
   endtask

   initial begin
      IC = 1'b1; c1 = 1'b1; sample_tick = 1'b1;
      timer_a_val = '0; timer_b_val = '0;
      load_a = 1'b1; load_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
      clr_a = 1'b0; clr_b = 1'b0;

      // Reset held for two updates while running.
      all_zero("rst0"); clk_check();
      all_zero("rst1"); clk_check();

      // Release reset with val_a=0: counts 1,2,3; Timer B prescaler not yet wrapped.
      IC = 1'b0;
      drv(1, 1); ea("rel1", 1, 0, 0); push("rel1.cnt_b", S_CB, 0); clk_check();
      drv(1, 1); ea("rel2", 2, 0, 0); clk_check();
      drv(1, 1); ea("rel3", 3, 0, 0); push("rel3.cnt_b", S_CB, 0); clk_check();

      // c1=0 blocks ticks and preloads.
      drv(0, 1); ea("c1lo1", 3, 0, 0); clk_check();
      load_a = 1'b0; timer_a_val = 10'd7;
      drv(0, 1); ea("c1lo2", 3, 0, 0); clk_check();

      // Timer A preload 1020, then run: period 4.
      timer_a_val = 10'd1020; load_b = 1'b0; en_a = 1'b1;
      drv(1, 0); ea("pre", 1020, 0, 0); clk_check();
      load_a = 1'b1;
      drv(1, 1); ea("a1", 1021, 0, 0); clk_check();
      drv(1, 1); ea("a2", 1022, 0, 0); clk_check();
      drv(1, 1); ea("a3", 1023, 0, 0); clk_check();
      drv(1, 1); ea("a4", 1020, 1, 1); clk_check();
      drv(1, 0); ea("a_idle", 1020, 1, 0); clk_check();
      drv(1, 1); ea("a5", 1021, 1, 0); clk_check();
      drv(1, 1); ea("a6", 1022, 1, 0); clk_check();
      drv(1, 1); ea("a7", 1023, 1, 0); clk_check();

      // Clear on the overflow tick: set wins.
      clr_a = 1'b1;
      drv(1, 1); ea("setwin", 1020, 1, 1); clk_check();
      // Plain clear.
      drv(1, 0); ea("clr", 1020, 0, 0); clk_check();
      clr_a = 1'b0;

      // en_a=0: overflow strobe continues, flag stays low.
      en_a = 1'b0;
      drv(1, 1); ea("noen1", 1021, 0, 0); clk_check();
      drv(1, 1); ea("noen2", 1022, 0, 0); clk_check();
      drv(1, 1); ea("noen3", 1023, 0, 0); clk_check();
      drv(1, 1); ea("noen4", 1020, 0, 1); clk_check();

      // Set again, then dropping en_a keeps the flag.
      en_a = 1'b1;
      drv(1, 1); ea("re1", 1021, 0, 0); clk_check();
      drv(1, 1); ea("re2", 1022, 0, 0); clk_check();
      drv(1, 1); ea("re3", 1023, 0, 0); clk_check();
      drv(1, 1); ea("re4", 1020, 1, 1); clk_check();
      en_a = 1'b0;
      drv(1, 0); ea("enoff", 1020, 1, 0); clk_check();
      clr_a = 1'b1;
      drv(1, 0); ea("clr2", 1020, 0, 0); clk_check();
      clr_a = 1'b0;

      // Mid-count value change only applies at reload.
      timer_a_val = 10'd1000;
      drv(1, 1); ea("mid1", 1021, 0, 0); clk_check();
      drv(1, 1); ea("mid2", 1022, 0, 0); clk_check();
      drv(1, 1); ea("mid3", 1023, 0, 0); clk_check();
      drv(1, 1); ea("mid4", 1000, 0, 1); clk_check();
      drv(1, 1); ea("mid5", 1001, 0, 0); clk_check();

      // Hold: counter follows the value, never overflows, even at all-ones.
      load_a = 1'b0; timer_a_val = 10'd5;
      drv(1, 1); ea("hold5", 5, 0, 0); clk_check();
      timer_a_val = 10'd900;
      drv(1, 1); ea("hold900", 900, 0, 0); clk_check();
      timer_a_val = 10'd1023;
      drv(1, 1); ea("hold1023", 1023, 0, 0); clk_check();

      // val=1023 running: overflow on every tick.
      load_a = 1'b1;
      drv(1, 1); ea("max1", 1023, 0, 1); clk_check();
      drv(1, 1); ea("max2", 1023, 0, 1); clk_check();

      // Timer B: preload 254, first overflow on tick 32, then every 32.
      load_a = 1'b0;
      timer_b_val = 8'd254;
      drv(1, 0); push("bpre.cnt_b", S_CB, 254); push("bpre.ovf_a", S_OVF, 0); clk_check();
      load_b = 1'b1; en_b = 1'b1;
      for (int t = 1; t <= 64; t++) begin
         int k;
         k = ((t - 1) % 32) + 1;
         clr_b = (t == 33);
         drv(1, 1);
         push($sformatf("b%0d.cnt_b", t), S_CB, (k < 16) ? 254 : ((k < 32) ? 255 : 254));
         push($sformatf("b%0d.timer_b", t), S_TB, (t == 32 || t == 64) ? 1 : 0);
         push($sformatf("b%0d.irq", t), S_IRQ, (t == 32 || t == 64) ? 1 : 0);
         clk_check();
      end
      clr_b = 1'b0;

      // Both flags set, then IC mid-period with c1=0 clears everything.
      load_a = 1'b1; en_a = 1'b1; timer_a_val = 10'd1023;
      drv(1, 1);
      push("both.timer_a", S_TA, 1); push("both.timer_b", S_TB, 1);
      push("both.irq", S_IRQ, 1); push("both.ovf_a", S_OVF, 1);
      clk_check();
      IC = 1'b1;
      drv(0, 1); all_zero("icmid"); clk_check();

      // Resume from preload after IC drops.
      IC = 1'b0; load_a = 1'b0; load_b = 1'b0; timer_a_val = 10'd1020;
      drv(1, 0);
      push("resume.cnt_a", S_CA, 1020); push("resume.cnt_b", S_CB, 254);
      push("resume.timer_a", S_TA, 0); push("resume.timer_b", S_TB, 0);
      clk_check();
      load_a = 1'b1;
      drv(1, 1); ea("resume1", 1021, 0, 0); clk_check();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ym3438_timers.md
Name: ym3438_timers

Overview:
Timer A / Timer B block for the YM3438 core. It feeds the io block's timer_a/timer_b status inputs and its IRQ, which are currently tied to 0 at the top level. It counts per-sample ticks from the fsm (fsm_timer_ed) using decoded register fields from reg_ctrl (regs 0x24–0x27). It raises status flags and an overflow strobe; the strobe is later consumed for CSM key-on.

Parameters:
A_W, 10, Timer A counter/value width
B_W, 8, Timer B counter/value width
B_PRE, 16, sample ticks per Timer B increment (power of two)

Ports:
MCLK  in  1  master clock; all state on rising edge
IC  in  1  synchronous active-high reset (internal qualified chip reset)
c1  in  1  phase enable; state updates only on MCLK edges with c1=1
sample_tick  in  1  one-per-sample strobe (fsm_timer_ed); counts only when c1=1
timer_a_val  in  A_W  Timer A reload value (regs 0x24/0x25)
timer_b_val  in  B_W  Timer B reload value (reg 0x26)
load_a  in  1  reg 0x27 bit0: run Timer A
load_b  in  1  reg 0x27 bit1: run Timer B
en_a  in  1  reg 0x27 bit2: allow Timer A flag set
en_b  in  1  reg 0x27 bit3: allow Timer B flag set
clr_a  in  1  write strobe of 0x27 with bit4=1: clear flag A
clr_b  in  1  write strobe of 0x27 with bit5=1: clear flag B
timer_a  out  1  Timer A status flag
timer_b  out  1  Timer B status flag
irq  out  1  timer_a OR timer_b (combinational from flags)
ovf_a  out  1  Timer A overflow strobe (CSM)
cnt_a  out  A_W  Timer A counter (debug)
cnt_b  out  B_W  Timer B counter (debug)

Behaviour:
- Reset (IC=1 on any edge, c1 ignored): cnt_a=0, cnt_b=0, prescaler=0, timer_a=0, timer_b=0, ovf_a=0. IC overrides everything mid-count.
- Update qualifier: upd = c1; tick = c1 & sample_tick. No state changes when c1=0.
- Timer A, load_a=0: on each upd, cnt_a <= timer_a_val (hold/preload); no overflow.
- Timer A, load_a=1, on each tick:
  - cnt_a != all-ones: cnt_a+1.
  - cnt_a == all-ones: overflow; cnt_a <= timer_a_val.
  - Period = 2^A_W − timer_a_val ticks. val=1023 gives an overflow every tick.
- Timer A value change while running takes effect only at the next reload.
- Timer B, load_b=0: cnt_b <= timer_b_val and prescaler <= 0 on each upd.
- Timer B, load_b=1: prescaler increments on each tick and wraps B_PRE−1 → 0.
  - On the tick where the prescaler wraps, cnt_b increments.
  - At cnt_b all-ones, that increment is an overflow and cnt_b <= timer_b_val.
  - Period = B_PRE·(2^B_W − timer_b_val) ticks.
- First count after load rises: counting starts on the first tick with load=1. The preloaded value is the start; the first increment happens on that tick.
- ovf_a: updated on every upd; 1 exactly for the upd following a Timer A overflow tick, else 0. Independent of en_a.
- Flags:
  - On an overflow tick with en_x=1: flag x <= 1.
  - On upd with clr_x=1 and no simultaneous set: flag x <= 0.
  - Simultaneous set and clear: set wins.
  - Clearing en_x does not clear an already-set flag.
  - Flag is unaffected by load_x.
- irq = timer_a | timer_b; no extra latency beyond the flag registers.
- Latency: a flag is visible on the MCLK edge that processes the overflow tick (zero added cycles).

Test Plan:
- Reset: IC=1 for 2 upd with load_a=load_b=1 → all outputs 0; release IC with val_a=0 → cnt_a counts 1,2,... per tick.
- Timer A: val_a=1020, load_a=1, en_a=1, tick every upd → overflow every 4 ticks. timer_a and irq rise on the 4th tick. ovf_a pulses for one upd per period. cnt_a sequence 1021,1022,1023,1020.
- Timer B: val_b=254, load_b=1, en_b=1 → first overflow on tick 32, then every 32 ticks. timer_b=1 at tick 32 and not before.
- Flag control: with flag A set, pulse clr_a → timer_a=0, irq=0. Pulse clr_a on the same upd as an overflow with en_a=1 → timer_a stays 1. en_a=0 → overflows continue (ovf_a pulses) but the flag stays 0.
- Load/hold: load_a=0 with val_a changed 5 → 900 → cnt_a follows the value on the next upd, no overflow. Mid-count change of val_a while load_a=1 → the new value is used only at the next reload.
- Qualifier/reset: sample_tick high with c1=0 → no change. Assert IC mid-period with flags set → all cleared the same edge; counting resumes from the preload after IC drops.
